// File: rtl/mips16_pkg.sv
// ============================================================================
// Module      : mips16_pkg
// Description : Shared opcode, state and control encodings for the MIPS16
//               multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips16_pkg;

    localparam logic [3:0] c_op_rtype = 4'b0000;
    localparam logic [3:0] c_op_addi  = 4'b0001;
    localparam logic [3:0] c_op_lw    = 4'b0010;
    localparam logic [3:0] c_op_sw    = 4'b0011;
    localparam logic [3:0] c_op_beq   = 4'b0100;
    localparam logic [3:0] c_op_j     = 4'b0101;
    localparam logic [3:0] c_op_halt  = 4'b1111;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    localparam logic [1:0] c_pcs_inc    = 2'b00;
    localparam logic [1:0] c_pcs_branch = 2'b01;
    localparam logic [1:0] c_pcs_jump   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    // Everything the state decoder produces; illegal_op is owned by the
    // next-state logic because it depends on the opcode.
    typedef struct packed {
        logic       alu_src;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic       pc_inc;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips16_multicycle_ctrl_if.sv
// ============================================================================
// Module      : mips16_ctrl_if
// Description : Controller <-> datapath signal bundle for the MIPS16 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips16_ctrl_if #(
    parameter int OPW = 4,
    parameter int STW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           alu_src;
    logic           alu_src_a;
    logic [1:0]     alu_op;
    logic           pc_inc;
    logic           pc_write;
    logic           pc_write_cond;
    logic [1:0]     pc_source;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           reg_write;
    logic           illegal_op;
    logic           halted;
    logic [STW-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_src, alu_src_a, alu_op, pc_inc, pc_write, pc_write_cond,
               pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, illegal_op, halted, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_src, alu_src_a, alu_op, pc_inc, pc_write, pc_write_cond,
               pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, illegal_op, halted, state
    );
endinterface

`default_nettype wire

// File: rtl/mips16_ctrl_decode.sv
// ============================================================================
// Module      : mips16_ctrl_decode
// Description : Combinational state-to-control decoder, forced idle in reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips16_ctrl_decode
    import mips16_pkg::*;
(
    input  wire logic   i_rst,
    input  state_t      i_state,
    input  wire logic   i_mem_ready,
    output ctrl_t       o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        if (!i_rst) begin
            case (i_state)
                S_FETCH: begin
                    o_ctrl.mem_read  = 1'b1;
                    o_ctrl.pc_inc    = 1'b1;
                    o_ctrl.alu_op    = c_alu_add;
                    o_ctrl.pc_source = c_pcs_inc;
                    // Only Mealy terms: IR and PC load in the cycle the fetch completes.
                    o_ctrl.ir_write  = i_mem_ready;
                    o_ctrl.pc_write  = i_mem_ready;
                end
                S_DECODE: begin
                    o_ctrl.alu_src = 1'b1;
                    o_ctrl.alu_op  = c_alu_add;
                end
                S_MEM_ADDR, S_EXEC_I: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.alu_op    = c_alu_add;
                end
                S_MEM_RD: begin
                    o_ctrl.mem_read = 1'b1;
                    o_ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    o_ctrl.mem_write = 1'b1;
                    o_ctrl.i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_op    = c_alu_funct;
                end
                S_R_WB: begin
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.reg_dst   = 1'b1;
                end
                S_I_WB: begin
                    o_ctrl.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    o_ctrl.alu_src_a     = 1'b1;
                    o_ctrl.alu_op        = c_alu_sub;
                    o_ctrl.pc_write_cond = 1'b1;
                    o_ctrl.pc_source     = c_pcs_branch;
                end
                S_JUMP: begin
                    o_ctrl.pc_write  = 1'b1;
                    o_ctrl.pc_source = c_pcs_jump;
                end
                S_HALT: begin
                    o_ctrl.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips16_multicycle_ctrl.sv
// ============================================================================
// Module      : mips16_multicycle_ctrl
// Description : Multi-cycle MIPS16 control FSM: state register, next-state
//               logic and control outputs driven onto the datapath bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips16_multicycle_ctrl
    import mips16_pkg::*;
#(
    parameter int OPW = 4,
    parameter int STW = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mips16_ctrl_if.master  bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_illegal;
    logic [3:0] w_op;
    ctrl_t      w_ctrl;
    logic       w_unused_zero;

    assign w_op          = 4'(bus.opcode);
    // The branch decision is made in the datapath, which gates pc_write_cond.
    assign w_unused_zero = bus.zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    c_op_rtype: w_next = S_EXEC_R;
                    c_op_addi:  w_next = S_EXEC_I;
                    c_op_lw:    w_next = S_MEM_ADDR;
                    c_op_sw:    w_next = S_MEM_ADDR;
                    c_op_beq:   w_next = S_BRANCH;
                    c_op_j:     w_next = S_JUMP;
                    c_op_halt:  w_next = S_HALT;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (w_op == c_op_lw)      w_next = S_MEM_RD;
                else if (w_op == c_op_sw) w_next = S_MEM_WR;
                else                      w_next = S_FETCH;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R: w_next = S_R_WB;
            S_EXEC_I: w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    mips16_ctrl_decode u_decode (
        .i_rst       (rst),
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.alu_src       = w_ctrl.alu_src;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.pc_inc        = w_ctrl.pc_inc;
    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.pc_write_cond = w_ctrl.pc_write_cond;
    assign bus.pc_source     = w_ctrl.pc_source;
    assign bus.i_or_d        = w_ctrl.i_or_d;
    assign bus.mem_read      = w_ctrl.mem_read;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.ir_write      = w_ctrl.ir_write;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.halted        = w_ctrl.halted;
    assign bus.illegal_op    = w_illegal & ~rst;
    assign bus.state         = STW'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mips16_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips16_multicycle_ctrl
// Description : Directed + randomized instruction stream against a per-cycle
//               expected state/control trace.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips16_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mips16_ctrl_if #(.OPW(4), .STW(4)) bus ();

    mips16_multicycle_ctrl #(.OPW(4), .STW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [17:0] obs;
    assign obs = {bus.alu_src, bus.alu_src_a, bus.alu_op, bus.pc_inc, bus.pc_write,
                  bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                  bus.reg_write, bus.illegal_op, bus.halted};

    // Expected control word for a state number, straight from the state table.
    function automatic logic [17:0] exp_out(input int st, input logic mr, input logic [3:0] opc);
        logic       a_src = 0, a_src_a = 0, pinc = 0, pw = 0, pwc = 0, iod = 0;
        logic       mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, ill = 0, hlt = 0;
        logic [1:0] aop = 0, psrc = 0;
        case (st)
            0:  begin mrd = 1; pinc = 1; irw = mr; pw = mr; end
            1:  begin a_src = 1; ill = !(opc inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15}); end
            2:  begin a_src_a = 1; a_src = 1; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin a_src_a = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin a_src_a = 1; a_src = 1; end
            9:  begin rw = 1; end
            10: begin a_src_a = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            11: begin pw = 1; psrc = 2'b10; end
            12: begin hlt = 1; end
            default: ;
        endcase
        return {a_src, a_src_a, aop, pinc, pw, pwc, psrc, iod, mrd, mwr, irw, rdst, m2r, rw, ill, hlt};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One clock cycle with the controller expected in state st; the opcode is
    // only meaningful in DECODE/MEM_ADDR and is noise everywhere else.
    task automatic cyc(input int st, input logic mr, input logic [3:0] opc);
        bus.mem_ready = mr;
        bus.zero      = 1'($urandom);
        bus.opcode    = (st == 1 || st == 2) ? opc : 4'($urandom);
        @(negedge clk);
        check($sformatf("state@s%0d op%0h", st, opc), 32'(bus.state), 32'(st));
        check($sformatf("ctrl@s%0d op%0h", st, opc), 32'(obs), 32'(exp_out(st, mr, bus.opcode)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] opc, input int fw, input int mw);
        repeat (fw) cyc(0, 1'b0, opc);
        cyc(0, 1'b1, opc);
        cyc(1, 1'($urandom), opc);
        case (opc)
            4'd0: begin cyc(6, 1'($urandom), opc); cyc(7, 1'($urandom), opc); end
            4'd1: begin cyc(8, 1'($urandom), opc); cyc(9, 1'($urandom), opc); end
            4'd2: begin
                cyc(2, 1'($urandom), opc);
                repeat (mw) cyc(3, 1'b0, opc);
                cyc(3, 1'b1, opc);
                cyc(4, 1'($urandom), opc);
            end
            4'd3: begin
                cyc(2, 1'($urandom), opc);
                repeat (mw) cyc(5, 1'b0, opc);
                cyc(5, 1'b1, opc);
            end
            4'd4:  cyc(10, 1'($urandom), opc);
            4'd5:  cyc(11, 1'($urandom), opc);
            4'd15: repeat (20) cyc(12, 1'($urandom), opc);
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] op;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 4'd0;
        repeat (2) begin
            @(negedge clk);
            check("reset state", 32'(bus.state), 32'd0);
            check("reset ctrl", 32'(obs), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(4'd0, 0, 0);
        run_instr(4'd1, 1, 0);
        run_instr(4'd2, 0, 3);
        run_instr(4'd7, 0, 0);
        run_instr(4'd4, 2, 0);
        run_instr(4'd5, 0, 0);
        run_instr(4'd3, 0, 1);

        // Abort a store mid-wait with an asynchronous reset.
        cyc(0, 1'b1, 4'd3);
        cyc(1, 1'b1, 4'd3);
        cyc(2, 1'b1, 4'd3);
        cyc(5, 1'b0, 4'd3);
        bus.mem_ready = 1'b0;
        #1;
        check("sw wait mem_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst mem_write", 32'(bus.mem_write), 32'd0);
        check("rst state", 32'(bus.state), 32'd0);
        check("rst ctrl", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                op = 4'($urandom_range(0, 5));
            end else begin
                op = 4'($urandom_range(6, 14));
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        run_instr(4'd15, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips16_multicycle_ctrl.md
Name: mips16_multicycle_ctrl

Overview:
- Moore-style multi-cycle control FSM for the 16-bit MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives `alu_src`, the select line of the ALU B-operand register/immediate mux, plus all datapath enables.
- Stalls on a memory ready handshake.

Parameters:
- OPW, 4, opcode width (instr[15:12])
- STW, 4, state register width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  OPW  instruction opcode from the IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- alu_src  output  1  B-mux select: 0 = register B, 1 = sign-extended immediate
- alu_src_a  output  1  A operand: 0 = PC, 1 = register A
- alu_op  output  2  00 add, 01 sub, 10 use funct
- pc_inc  output  1  PC+1 adder result selected onto PC input
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero
- pc_source  output  2  00 PC+1, 01 branch target, 10 jump target
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- halted  output  1  FSM is in HALT
- state  output  STW  current state, for debug

Behaviour:
- Opcodes: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 j, 1111 halt; all others illegal.
- Reset (async): state <= FETCH. While rst=1, every output is 0 and state reads 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, HALT=12.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, pc_inc=1, alu_src_a=0, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready; these two are the only Mealy outputs.
  - Stay while mem_ready=0; go to DECODE when 1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src=1, alu_op=00 (precomputes branch target).
  - Next state by opcode: lw/sw -> MEM_ADDR, R -> EXEC_R, addi -> EXEC_I, beq -> BRANCH, j -> JUMP, halt -> HALT.
  - Illegal opcode -> FETCH, with illegal_op=1 for that cycle.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src=1, alu_op=00.
  - Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready=1, then FETCH.
- EXEC_R: alu_src_a=1, alu_src=0, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- EXEC_I: alu_src_a=1, alu_src=1, alu_op=00. Next: I_WB.
- I_WB: reg_write=1, reg_dst=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src=0, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH (the datapath gates with zero).
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- HALT: halted=1, all enables 0. Exit only by reset.
- Cycle counts, excluding memory waits: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR is stable because ir_write=0 outside FETCH.
- Reset asserted mid-instruction aborts it immediately: no write strobe is emitted after the rst rising edge.
- Undefined state encodings (13-15) go to FETCH.

Decomposition:
- Shared package `mips16_pkg` holds:
  - opcode constants
  - state constants
  - alu_op and pc_source encodings
- One sub-module, `mips16_ctrl_decode`: combinational state-to-output decoder.
- The top holds the state register and next-state logic.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset; first cycle state=0 with mem_read=1, ir_write=1, pc_write=1.
- R-type (opcode 0000), mem_ready=1 -> states 0,1,6,7,0; alu_src=0 in EXEC_R; reg_write=1 and reg_dst=1 in R_WB.
- addi (opcode 0001) -> states 0,1,8,9; alu_src=1 in EXEC_I.
- lw (opcode 0010), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; then MEM_WB with mem_to_reg=1.
- Illegal opcode 0111 -> illegal_op pulses exactly 1 cycle in DECODE, then FETCH.
- Halt opcode 1111 -> halted stays 1 indefinitely.
- Reset asserted in MEM_WR -> mem_write drops the same cycle; state returns to 0.
